// File: rtl/life_cursor_ctrl.sv
// life_cursor_ctrl
// Cursor and flip-request controller for the low board-storage stage of the
// Life engine. Button levels become single-shot presses; presses move a
// wrapping cursor or request a cell flip. The board rotates one bit per
// clock, so an accepted flip is held pending and only presented downstream
// in the cycle where the rotation phase is N-1, which is the one cycle where
// the post-rotation physical index equals the logical cell index.

module life_cursor_ctrl #(
  parameter int X         = 8,
  parameter int Y         = 8,
  parameter int HIGH_BITS = X + 3,
  parameter int LOG2X     = 3,
  parameter int LOG2Y     = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_btn_up,
  input  logic                     i_btn_down,
  input  logic                     i_btn_left,
  input  logic                     i_btn_right,
  input  logic                     i_btn_flip,
  output logic [LOG2X-1:0]         o_cursor_x,
  output logic [LOG2Y-1:0]         o_cursor_y,
  output logic                     o_cell_flip,
  output logic                     o_flip_pending,
  output logic                     o_flip_reject,
  output logic [LOG2X+LOG2Y-1:0]   o_phase,
  output logic                     o_gen_tick
);

  localparam int N        = X * Y;
  localparam int LOW_BITS = N - HIGH_BITS;
  localparam int PW       = LOG2X + LOG2Y;

  // Phase values of interest; guarded so a degenerate N=1 board elaborates.
  localparam logic [PW-1:0] PH_MAX = PW'((N > 1) ? N - 1 : 0);
  localparam logic [PW-1:0] PH_PRE = PW'((N > 1) ? N - 2 : 0);

  // Extra bit so the comparison stays correct even if LOW_BITS == N.
  localparam logic [PW:0] LOW_LIMIT = (PW + 1)'(LOW_BITS);

  localparam logic [LOG2X-1:0] X_MAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_MAX = LOG2Y'(Y - 1);

  // Bit positions within the packed button vector.
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_FLIP  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t            r_state;
  logic [4:0]        r_btn_q;
  logic [LOG2X-1:0]  r_cursor_x;
  logic [LOG2Y-1:0]  r_cursor_y;
  logic [PW-1:0]     r_phase;
  logic              r_cell_flip;
  logic              r_flip_reject;
  logic              r_gen_tick;

  logic [4:0]        w_btn;
  logic [4:0]        w_press;
  logic [PW-1:0]     w_target;
  logic              w_target_low;
  logic              w_idle;
  logic              w_flip_accept;
  logic              w_flip_reject;
  logic              w_move_en;
  logic              w_issue_edge;
  logic [PW-1:0]     w_phase_next;
  logic [LOG2X-1:0]  w_cursor_x_next;
  logic [LOG2Y-1:0]  w_cursor_y_next;

  assign w_btn   = {i_btn_flip, i_btn_up, i_btn_down, i_btn_left, i_btn_right};
  assign w_press = w_btn & ~r_btn_q;

  // X is a power of two, so y*X + x is simply the concatenation {y, x}.
  assign w_target     = {r_cursor_y, r_cursor_x};
  assign w_target_low = ({1'b0, w_target} < LOW_LIMIT);

  // Flip has top priority: a flip press consumes the cycle even when it is
  // rejected or ignored, so any move pressed alongside it is dropped.
  assign w_idle        = (r_state == IDLE);
  assign w_flip_accept = w_press[B_FLIP] & w_idle & w_target_low;
  assign w_flip_reject = w_press[B_FLIP] & w_idle & ~w_target_low;
  assign w_move_en     = ~w_press[B_FLIP] & w_idle;

  // The issue edge is the one that carries phase from N-2 to N-1.
  assign w_issue_edge = (N == 1) ? 1'b1 : (r_phase == PH_PRE);

  // Next rotation phase, wrapping N-1 -> 0 and pinned at 0 when N == 1.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    w_phase_next = r_phase + PW'(1);
    if ((N == 1) || (r_phase == PH_MAX)) begin
      w_phase_next = '0;
    end
  end

  // Next cursor position: one move per cycle, up > down > left > right.
  always_comb begin
    w_cursor_x_next = r_cursor_x;
    w_cursor_y_next = r_cursor_y;
    if (w_move_en) begin
      if (w_press[B_UP]) begin
        w_cursor_y_next = (r_cursor_y == '0) ? Y_MAX : r_cursor_y - LOG2Y'(1);
      end else if (w_press[B_DOWN]) begin
        w_cursor_y_next = (r_cursor_y == Y_MAX) ? '0 : r_cursor_y + LOG2Y'(1);
      end else if (w_press[B_LEFT]) begin
        w_cursor_x_next = (r_cursor_x == '0) ? X_MAX : r_cursor_x - LOG2X'(1);
      end else if (w_press[B_RIGHT]) begin
        w_cursor_x_next = (r_cursor_x == X_MAX) ? '0 : r_cursor_x + LOG2X'(1);
      end
    end
  end

  // Flip FSM plus all registered state and outputs, with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: reset is synchronous because downstream shares it, so phase 0
      // lines up exactly with the reset board layout.
      r_state       <= IDLE;
      r_btn_q       <= '0;
      r_cursor_x    <= '0;
      r_cursor_y    <= '0;
      r_phase       <= '0;
      r_cell_flip   <= 1'b0;
      r_flip_reject <= 1'b0;
      r_gen_tick    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here see the
      // pre-edge values of the others, which is what lets issue be judged on
      // the already-registered pending state.
      r_btn_q       <= w_btn;
      r_cursor_x    <= w_cursor_x_next;
      r_cursor_y    <= w_cursor_y_next;
      r_phase       <= w_phase_next;
      r_gen_tick    <= w_issue_edge;
      r_flip_reject <= w_flip_reject;
      r_cell_flip   <= 1'b0;

      case (r_state)
        IDLE: begin
          // A flip accepted on the issue edge itself waits a generation.
          if (w_flip_accept) begin
            r_state <= PEND;
          end
        end
        PEND: begin
          if (w_issue_edge) begin
            r_cell_flip <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_cursor_x     = r_cursor_x;
  assign o_cursor_y     = r_cursor_y;
  assign o_cell_flip    = r_cell_flip;
  assign o_flip_pending = (r_state == PEND);
  assign o_flip_reject  = r_flip_reject;
  assign o_phase        = r_phase;
  assign o_gen_tick     = r_gen_tick;

endmodule

// File: doc/life_cursor_ctrl.md
# life_cursor_ctrl

Generates the `cell_flip`, `cursor_x` and `cursor_y` controls for the low board-storage stage of the Life engine, which sits directly downstream. The board shift register rotates by one bit every clock, so a given physical bit index maps to a different logical cell on each cycle. This block turns debounced button levels into cursor moves and flip requests. It tracks the rotation phase and fires `cell_flip` only on the one cycle per generation when physical index equals logical cell index.

## Interface
Parameters:
- `X`, 8: board width in cells.
- `Y`, 8: board height in cells.
- `HIGH_BITS`, X+3: cells held by the high storage stage. Must match downstream.
- `LOG2X`, 3: width of `cursor_x`. X == 2**LOG2X.
- `LOG2Y`, 3: width of `cursor_y`. Y == 2**LOG2Y.
- Derived: N = X*Y, LOW_BITS = N-HIGH_BITS, PW = LOG2X+LOG2Y.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_flip`  in  1 each  debounced, clk-synchronous button levels.
- `cursor_x`  out  LOG2X  cursor column, registered.
- `cursor_y`  out  LOG2Y  cursor row, registered.
- `cell_flip`  out  1  registered one-cycle flip strobe to downstream.
- `flip_pending`  out  1  a flip is accepted and waiting for alignment.
- `flip_reject`  out  1  one-cycle pulse when a flip targets a high-stage cell.
- `phase`  out  PW  rotation phase, 0..N-1.
- `gen_tick`  out  1  one-cycle pulse while `phase` == N-1.

## Operation
- Edge detect: each button is registered into a `_q` copy. A press is `btn & ~btn_q`. Held buttons produce exactly one press.
- Only one action is taken per cycle. Priority is flip > up > down > left > right. Lower-priority presses in the same cycle are dropped.
- Cursor moves:
  - up: y-1. down: y+1. left: x-1. right: x+1.
  - Each axis wraps independently: 0-1 goes to max, max+1 goes to 0.
  - Moves are ignored while `flip_pending`=1, so the cursor is stable through the flip.
- Flip press:
  - Target index L = cursor_y*X + cursor_x.
  - If L >= LOW_BITS, pulse `flip_reject` for one cycle and set no pending flag.
  - Otherwise set `flip_pending`.
  - A flip press while already pending is ignored, with no reject.
- Phase counter:
  - `phase` increments every cycle and wraps N-1 -> 0.
  - `phase`==0 means the board is aligned, i.e. logical cell i is at physical index i.
  - Downstream applies the flip to the post-rotation value, so the flip must be presented in the cycle where `phase`==N-1.
- Flip issue: on the edge where `phase` goes N-2 -> N-1 with `flip_pending`=1:
  - set `cell_flip`=1 for that one cycle;
  - clear `flip_pending` on the same edge.
- State machine `IDLE` / `PEND` (`flip_pending` = state==PEND):
  - IDLE -> PEND on an accepted flip press.
  - PEND -> IDLE on the issue edge.
- A flip accepted on the N-2 -> N-1 edge itself waits for the next generation. The pending flag must be registered before issue is evaluated.

## Timing
- Reset values: `cursor_x`=0, `cursor_y`=0, `phase`=0, `cell_flip`=0, `flip_pending`=0, `flip_reject`=0, `gen_tick`=0, all `_q`=0.
- Reset is shared with downstream so that phase 0 coincides with the reset board layout.
- Reset asserted mid-PEND drops the pending flip. No `cell_flip` is emitted.
- Cursor move latency: button rises at edge k, press is seen in cycle k, cursor updates at edge k+1.
- `flip_reject` is asserted in the cycle after the press cycle.
- Flip latency from press to `cell_flip` ranges from 2 to N+1 cycles.
- `cell_flip` is never high for two consecutive cycles. It is high at most once per N cycles.
- `gen_tick` is high exactly when `phase`==N-1. `cell_flip` implies `gen_tick`.
- With N=1 the phase register is held at 0 and flips issue the cycle after acceptance. This case is not expected in practice; the defaults give N=64.

## Test plan
- Reset, then run 130 cycles idle:
  - `phase` goes 0..63, 0..63, 0, 1;
  - `gen_tick` is high at cycles 63 and 127 only;
  - all other outputs stay 0.
- Wrap on both axes:
  - press left once from (0,0) -> `cursor_x`=7;
  - press up once -> `cursor_y`=7;
  - hold right for 10 cycles -> exactly one move, `cursor_x`=0.
- Flip at cursor (3,2), L=19:
  - press at `phase`=10 -> `flip_pending` is 1 from the next cycle;
  - `cell_flip` is high only at `phase`=63 with `cursor_x`=3, `cursor_y`=2;
  - `flip_pending` is 0 at `phase`=0.
- Reject: cursor (5,6), L=53, press flip -> one `flip_reject` pulse, `flip_pending` stays 0, no `cell_flip` in the next 64 cycles.
- Simultaneous and blocked presses:
  - up+flip pressed in the same cycle -> flip accepted, `cursor_y` unchanged;
  - right pressed while pending -> `cursor_x` unchanged.
- Flip accepted on the edge into `phase`=63 -> no `cell_flip` that cycle; `cell_flip` at the following `phase`=63.
- Assert `reset` at `phase`=40 while PEND -> all outputs reset, and no `cell_flip` in the following 64 cycles.
